// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 serial receiver with a 2-flop synchroniser, glitch rejection,
//            framing/overrun detection and a show-ahead receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clear
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam int c_PW    = c_AW + 1;
    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_IDLE      = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_STOP      = 3'd4
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    logic [1:0]         r_prime;
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shreg;
    logic               r_busy;
    logic               r_frame_err;
    logic               r_push_req;
    logic [7:0]         r_push_data;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]    r_wr_ptr;
    logic [c_PW-1:0]    r_rd_ptr;
    logic               r_overrun;

    logic               w_rx_s;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push_ok;

    assign w_rx_s = r_sync2;

    // The sync flops reset to 1, which is not a real line sample; r_prime
    // marks when both flops hold genuine rx values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prime <= 2'b00;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prime <= {r_prime[0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_WAIT_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shreg     <= 8'h00;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_push_req  <= 1'b0;
            r_push_data <= 8'h00;
        end else begin
            r_push_req <= 1'b0;
            if (err_clear) begin
                r_frame_err <= 1'b0;
            end
            case (r_state)
                S_WAIT_IDLE: begin
                    if (r_prime[1] && w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt   <= '0;
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == c_HALF) begin
                        if (!w_rx_s) begin
                            r_cnt     <= '0;
                            r_bit_idx <= 3'd0;
                            r_state   <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_FULL) begin
                        r_shreg <= {w_rx_s, r_shreg[7:1]};
                        r_cnt   <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_FULL) begin
                        r_busy <= 1'b0;
                        if (w_rx_s) begin
                            r_push_req  <= 1'b1;
                            r_push_data <= r_shreg;
                            r_state     <= S_IDLE;
                        end else begin
                            // A low stop bit may be a break; wait for idle line.
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_WAIT_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                       (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
    assign w_pop     = !w_empty && data_ready;
    assign w_push_ok = r_push_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (err_clear) begin
                r_overrun <= 1'b0;
            end
            if (r_push_req && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end
            if (w_push_ok) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= r_push_data;
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
        end
    end

    assign data_out   = r_mem[r_rd_ptr[c_AW-1:0]];
    assign data_valid = !w_empty;
    assign busy       = r_busy;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
